// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the 8-digit common-anode 7-segment scan driver.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

  localparam int DISP_DATA_W = 64;
  localparam int NUM_DIGITS  = 8;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_RAW = 1'b1;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef struct packed {
    logic [DISP_DATA_W-1:0] data;
    logic                   mode;
    logic                   page;
  } disp_word_t;

  // The page bit only matters in hex mode; raw mode always shows all 8 bytes.
  function automatic logic [31:0] hex_half(input disp_word_t w);
    return w.page ? w.data[63:32] : w.data[31:0];
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Update port of the scan driver: display word plus mode/page under valid/ready.
// The producer (CPU watch mux) is the master, the driver is the slave.
interface seg_scan_driver_if;
  import seg_scan_driver_pkg::*;

  logic [DISP_DATA_W-1:0] disp_data_i;
  logic                   disp_valid_i;
  logic                   disp_ready_o;
  logic                   mode_i;
  logic                   page_i;

  modport master (
    output disp_data_i,
    output disp_valid_i,
    output mode_i,
    output page_i,
    input  disp_ready_o
  );

  modport slave (
    input  disp_data_i,
    input  disp_valid_i,
    input  mode_i,
    input  page_i,
    output disp_ready_o
  );

endinterface

// File: rtl/seg_scan_driver_hex7seg.sv
// Combinational 4-bit value to active-low 7-segment code, decimal point off.
// Zero latency, no flow control.
module seg_scan_driver_hex7seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver; seg/an registered (1 cycle after index/prescaler).
// One-deep pending buffer: ready drops after a capture and returns when it commits at the next frame wrap.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter bit LZ_BLANK  = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  seg_scan_driver_if.slave   disp,
  output logic [7:0]         disp_seg_o,
  output logic [7:0]         disp_an_o,
  output logic               frame_o
);

  localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]   BLANK_END = PW'(BLANK_CYC);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  disp_word_t    pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  disp_word_t    shad_q, shad_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          boundary;
  logic          take;
  logic          commit;
  logic [31:0]   half;
  logic [3:0]    nib;
  logic [7:0]    raw_byte;
  logic          upper_zero;
  logic [7:0]    hex_seg;

  seg_scan_driver_hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  // Scan timing and update handshake.
  always_comb begin
    tick        = (presc_q == PRESC_MAX);
    boundary    = tick && (idx_q == 3'd7);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;

    take        = disp.disp_valid_i && !pend_full_q;
    commit      = boundary && pend_full_q;

    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    shad_d      = shad_q;
    frame_d     = boundary;

    // take and commit are mutually exclusive: both depend on pend_full_q with opposite sense.
    if (take) begin
      pend_d.data = disp.disp_data_i;
      pend_d.mode = disp.mode_i;
      pend_d.page = disp.page_i;
      pend_full_d = 1'b1;
    end else if (commit) begin
      shad_d      = pend_q;
      pend_full_d = 1'b0;
    end
  end

  // Digit decode from the shadow word; only the shadow feeds the display, so no tearing.
  always_comb begin
    half       = hex_half(shad_q);
    nib        = half[{idx_q, 2'b00} +: 4];
    raw_byte   = shad_q.data[{idx_q, 3'b000} +: 8];
    upper_zero = ((half >> {idx_q, 2'b00}) == 32'd0);

    seg_d = hex_seg;
    if (shad_q.mode == MODE_RAW) begin
      seg_d = raw_byte;
    end else if (LZ_BLANK && (idx_q != 3'd0) && upper_zero) begin
      seg_d = SEG_OFF;
    end

    an_d = ~(8'h01 << idx_q);
    if (presc_q < BLANK_END) begin
      an_d = AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q     <= '0;
      idx_q       <= 3'd0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      shad_q      <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      shad_q      <= shad_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign disp.disp_ready_o = ~pend_full_q;
  assign disp_seg_o        = seg_q;
  assign disp_an_o         = an_q;
  assign frame_o           = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (LZ_BLANK=0/1) share stimulus and a frame-level reference model.
// Directed vector table, hand-written handshake/reset sequences, then randomized updates.
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * SCAN_DIV;
  localparam int NV        = 10;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] d_data;
  logic        d_valid;
  logic        d_mode;
  logic        d_page;

  logic [7:0]  seg_a, an_a, seg_b, an_b;
  logic        frame_a, frame_b;

  int checks   = 0;
  int failures = 0;

  seg_scan_driver_if if_a ();
  seg_scan_driver_if if_b ();

  assign if_a.disp_data_i  = d_data;
  assign if_a.disp_valid_i = d_valid;
  assign if_a.mode_i       = d_mode;
  assign if_a.page_i       = d_page;
  assign if_b.disp_data_i  = d_data;
  assign if_b.disp_valid_i = d_valid;
  assign if_b.mode_i       = d_mode;
  assign if_b.page_i       = d_page;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_BLANK(1'b0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .disp       (if_a),
    .disp_seg_o (seg_a),
    .disp_an_o  (an_a),
    .frame_o    (frame_a)
  );

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .LZ_BLANK(1'b1)) dut_lz (
    .clk        (clk),
    .rstn       (rstn),
    .disp       (if_b),
    .disp_seg_o (seg_b),
    .disp_an_o  (an_b),
    .frame_o    (frame_b)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] ref_seg(input logic [63:0] w, input logic m, input logic p,
                                         input int k, input bit lz);
    logic [31:0] half;
    if (m) return w[8*k +: 8];
    half = p ? w[63:32] : w[31:0];
    if (lz && k > 0 && (half >> (4*k)) == 32'd0) return 8'hFF;
    return hex_tab[half[4*k +: 4]];
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: position in the frame follows from the edge count since reset release.
  int          m_cyc = 0;
  bit          m_pend_full = 1'b0;
  logic [63:0] m_pend_data = '0;
  logic        m_pend_mode = 1'b0, m_pend_page = 1'b0;
  logic [63:0] sh_data = '0;
  logic        sh_mode = 1'b0, sh_page = 1'b0;
  logic [7:0]  exp_seg = 8'hFF, exp_seg_lz = 8'hFF, exp_an = 8'hFF;
  logic        exp_frame = 1'b0;

  initial begin
    int presc, idx;
    bit boundary;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_cyc = 0; m_pend_full = 1'b0;
        sh_data = '0; sh_mode = 1'b0; sh_page = 1'b0;
        exp_seg = 8'hFF; exp_seg_lz = 8'hFF; exp_an = 8'hFF; exp_frame = 1'b0;
      end else begin
        presc      = m_cyc % SCAN_DIV;
        idx        = (m_cyc / SCAN_DIV) % 8;
        boundary   = (m_cyc % FRAME) == FRAME - 1;
        exp_seg    = ref_seg(sh_data, sh_mode, sh_page, idx, 1'b0);
        exp_seg_lz = ref_seg(sh_data, sh_mode, sh_page, idx, 1'b1);
        exp_an     = (presc < BLANK_CYC) ? 8'hFF : ~(8'h01 << idx);
        exp_frame  = boundary;
        if (boundary && m_pend_full) begin
          sh_data = m_pend_data; sh_mode = m_pend_mode; sh_page = m_pend_page;
          m_pend_full = 1'b0;
        end else if (d_valid && !m_pend_full) begin
          m_pend_data = d_data; m_pend_mode = d_mode; m_pend_page = d_page;
          m_pend_full = 1'b1;
        end
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check8("mon_seg",      seg_a,   exp_seg);
      check8("mon_seg_lz",   seg_b,   exp_seg_lz);
      check8("mon_an",       an_a,    exp_an);
      check8("mon_an_lz",    an_b,    exp_an);
      check8("mon_frame",    {7'b0, frame_a}, {7'b0, exp_frame});
      check8("mon_frame_lz", {7'b0, frame_b}, {7'b0, exp_frame});
      check8("mon_ready",    {7'b0, if_a.disp_ready_o}, {7'b0, ~m_pend_full});
      check8("mon_ready_lz", {7'b0, if_b.disp_ready_o}, {7'b0, ~m_pend_full});
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic send(input logic [63:0] data, input logic mode, input logic page);
    d_data = data; d_mode = mode; d_page = page; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (if_a.disp_ready_o !== 1'b1 && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check8(name, {7'b0, if_a.disp_ready_o}, 8'h01);
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((m_cyc % FRAME) != ph && n < 2 * FRAME);
  endtask

  task automatic wait_an(input logic [7:0] want, input string name);
    int n = 0;
    while (an_a !== want && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check8(name, an_a, want);
  endtask

  typedef struct {
    logic [63:0] data;
    logic        mode;
    logic        page;
    logic [63:0] exp;
    logic [63:0] exp_lz;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int          k, lit, gap, hold, sel;
    logic [63:0] rd;

    vecs[0] = '{64'h0000_0000_1234_ABCF, 1'b0, 1'b0, 64'hF9A4_B099_8883_C68E, 64'hF9A4_B099_8883_C68E};
    vecs[1] = '{64'h0000_0000_1234_ABCF, 1'b0, 1'b1, 64'hC0C0_C0C0_C0C0_C0C0, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[2] = '{64'h7FBF_DFEF_F7FB_FDFE, 1'b1, 1'b0, 64'h7FBF_DFEF_F7FB_FDFE, 64'h7FBF_DFEF_F7FB_FDFE};
    vecs[3] = '{64'h7FBF_DFEF_F7FB_FDFE, 1'b1, 1'b1, 64'h7FBF_DFEF_F7FB_FDFE, 64'h7FBF_DFEF_F7FB_FDFE};
    vecs[4] = '{64'h0000_0000_0000_00A0, 1'b0, 1'b0, 64'hC0C0_C0C0_C0C0_88C0, 64'hFFFF_FFFF_FFFF_88C0};
    vecs[5] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 64'hC0C0_C0C0_C0C0_C0C0, 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[6] = '{64'hFEDC_BA98_0000_0000, 1'b0, 1'b1, 64'h8E86_A1C6_8388_9080, 64'h8E86_A1C6_8388_9080};
    vecs[7] = '{64'h0000_0765_FFFF_FFFF, 1'b0, 1'b1, 64'hC0C0_C0C0_C0F8_8292, 64'hFFFF_FFFF_FFF8_8292};
    vecs[8] = '{64'hFFFF_FFFF_0000_1000, 1'b0, 1'b0, 64'hC0C0_C0C0_F9C0_C0C0, 64'hFFFF_FFFF_F9C0_C0C0};
    vecs[9] = '{64'h0000_0000_0000_0000, 1'b1, 1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

    rstn = 1'b0; d_valid = 1'b0; d_data = '0; d_mode = 1'b0; d_page = 1'b0;
    repeat (3) @(negedge clk);
    check8("rst_seg",   seg_a, 8'hFF);
    check8("rst_seg_lz", seg_b, 8'hFF);
    check8("rst_an",    an_a,  8'hFF);
    check8("rst_ready", {7'b0, if_a.disp_ready_o}, 8'h01);
    check8("rst_frame", {7'b0, frame_a}, 8'h00);
    rstn = 1'b1;

    // First slot: anode 0 lit for prescaler counts 2..7, shown one cycle later.
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check8($sformatf("first_slot_an%0d", j), an_a, (j >= 3 && j <= 8) ? 8'hFE : 8'hFF);
    end

    for (int v = 0; v < NV; v++) begin
      wait_ready($sformatf("tbl%0d_idle", v));
      send(vecs[v].data, vecs[v].mode, vecs[v].page);
      check8($sformatf("tbl%0d_busy", v), {7'b0, if_a.disp_ready_o}, 8'h00);
      wait_ready($sformatf("tbl%0d_commit", v));
      lit = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if (an_a !== 8'hFF) begin
          k = -1;
          for (int b = 0; b < 8; b++) if (an_a == ~(8'h01 << b)) k = b;
          if (k < 0) begin
            check8($sformatf("tbl%0d_an_onehot", v), an_a, 8'hFE);
          end else begin
            lit++;
            check8($sformatf("tbl%0d_d%0d", v, k), seg_a, vecs[v].exp[8*k +: 8]);
            check8($sformatf("tbl%0d_lz_d%0d", v, k), seg_b, vecs[v].exp_lz[8*k +: 8]);
          end
        end
      end
      check_int($sformatf("tbl%0d_lit_count", v), lit, 8 * (SCAN_DIV - BLANK_CYC));
    end

    // Mid-frame update: ready drops at once, word appears only after the wrap.
    wait_phase(20);
    send(64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    check8("mid_ready_drop", {7'b0, if_a.disp_ready_o}, 8'h00);
    wait_ready("mid_commit");
    check8("mid_frame_pulse", {7'b0, frame_a}, 8'h01);
    @(negedge clk);
    check8("mid_frame_single", {7'b0, frame_a}, 8'h00);
    wait_an(8'hFE, "mid_an_digit0");
    check8("mid_new_digit0", seg_a, 8'h8E);

    // Second valid while full is ignored; valid on the boundary cycle is dropped.
    wait_phase(10);
    send(64'h0102_0408_1020_4080, 1'b1, 1'b0);
    wait_phase(20);
    send(64'h0000_0000_0000_1111, 1'b0, 1'b0);
    check8("full_ignore_ready", {7'b0, if_a.disp_ready_o}, 8'h00);
    wait_phase(FRAME - 1);
    send(64'h0000_0000_0000_2222, 1'b0, 1'b0);
    check8("bnd_drop_ready", {7'b0, if_a.disp_ready_o}, 8'h01);
    check8("bnd_frame", {7'b0, frame_a}, 8'h01);
    wait_an(8'hFE, "bnd_an_digit0");
    check8("bnd_commit_first", seg_a, 8'h80);
    repeat (FRAME) @(negedge clk);
    check8("bnd_no_late_capture", {7'b0, if_a.disp_ready_o}, 8'h01);

    for (int r = 0; r < 40; r++) begin
      gap  = $urandom_range(0, 2 * FRAME);
      hold = $urandom_range(1, 3);
      sel  = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      rd = {$urandom, $urandom};
      if (sel == 0) rd = rd >> $urandom_range(0, 63);
      else if (sel == 1) rd = rd & 64'h0000_F00F_0000_0F0F;
      d_data = rd; d_mode = $urandom_range(0, 1); d_page = $urandom_range(0, 1);
      d_valid = 1'b1;
      repeat (hold) @(negedge clk);
      d_valid = 1'b0;
    end

    // Reset mid-slot with an update pending: outputs off immediately, update lost.
    wait_ready("rst_mid_idle");
    send(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
    begin
      int n = 0;
      while (an_a === 8'hFF && n < 2 * FRAME) begin @(negedge clk); n++; end
    end
    #2 rstn = 1'b0;
    #1;
    check8("rst_mid_seg",    seg_a, 8'hFF);
    check8("rst_mid_seg_lz", seg_b, 8'hFF);
    check8("rst_mid_an",     an_a,  8'hFF);
    check8("rst_mid_ready",  {7'b0, if_a.disp_ready_o}, 8'h01);
    check8("rst_mid_frame",  {7'b0, frame_a}, 8'h00);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < FRAME + SCAN_DIV; c++) begin
      @(negedge clk);
      if (an_a == 8'hFE) begin
        check8("post_rst_d0", seg_a, 8'hC0);
        check8("post_rst_lz_d0", seg_b, 8'hC0);
      end else if (an_a == 8'hFD) begin
        check8("post_rst_d1", seg_a, 8'hC0);
        check8("post_rst_lz_d1", seg_b, 8'hFF);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
